// File: rtl/md_pkg.sv
// ============================================================================
// Module      : md_pkg
// Description : Shared state encoding and ALU opcodes for the iterative
//               multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MULT = ST_MULT,
    DIV  = ST_DIV,
    DONE = ST_DONE
  } md_state_e;

  // Opcodes shared with execute-stage decode and rstatus generation
  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/md_negate.sv
// ============================================================================
// Module      : md_negate
// Description : WIDTH-bit two's-complement conditional negate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? -in : in;

endmodule

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ============================================================================
// Module      : multdiv_iter
// Description : Iterative signed multiply (shift-add) / divide (restoring),
//               one bit per cycle, with tag passthrough and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_iter
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] tag_out,
  output logic             op_div
);

  localparam int               CNT_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [WIDTH:0]   PROD_HI_ONE = (WIDTH+1)'(1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sign_q, sign_d;
  logic               div_q, div_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic               op_div_q, op_div_d;

  logic [WIDTH-1:0]   a_mag, b_mag, fixed;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_step;
  logic               accept, div_by_zero, mul_fits, final_exc;

  md_negate #(.WIDTH(WIDTH)) u_neg_a   (.in(operand_a), .neg(operand_a[WIDTH-1]), .out(a_mag));
  md_negate #(.WIDTH(WIDTH)) u_neg_b   (.in(operand_b), .neg(operand_b[WIDTH-1]), .out(b_mag));
  md_negate #(.WIDTH(WIDTH)) u_neg_res (.in(acc_step[WIDTH-1:0]), .neg(sign_q), .out(fixed));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_step  = div_q ? div_next : mul_next;

    div_by_zero = (opnd_q == '0);
    // Product magnitude fits when below 2^(W-1), or equal to it for a negative result
    mul_fits  = (acc_step[2*WIDTH-1:WIDTH-1] == '0)
             || (sign_q && (acc_step[2*WIDTH-1:WIDTH-1] == PROD_HI_ONE)
                        && (acc_step[WIDTH-2:0] == '0));
    final_exc = div_q ? (div_by_zero || (!sign_q && acc_step[WIDTH-1])) : !mul_fits;
  end

  assign accept = !flush && ((state_q == IDLE) || (state_q == DONE)) && (start_mult || start_div);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    sign_d    = sign_q;
    div_d     = div_q;
    tag_d     = tag_q;
    ready_d   = 1'b0;
    result_d  = result_q;
    exc_d     = exc_q;
    tag_out_d = tag_out_q;
    op_div_d  = op_div_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MULT, DIV: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d   = DONE;
            ready_d   = 1'b1;
            result_d  = (div_q && div_by_zero) ? '0 : fixed;
            exc_d     = final_exc;
            tag_out_d = tag_q;
            op_div_d  = div_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (accept) begin
        state_d = start_mult ? MULT : DIV;
        cnt_d   = CNT_LOAD;
        div_d   = !start_mult;
        acc_d   = {{WIDTH{1'b0}}, (start_mult ? b_mag : a_mag)};
        opnd_d  = start_mult ? a_mag : b_mag;
        sign_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        tag_d   = tag_in;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      sign_q    <= 1'b0;
      div_q     <= 1'b0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      tag_out_q <= '0;
      op_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      sign_q    <= sign_d;
      div_q     <= div_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      tag_out_q <= tag_out_d;
      op_div_q  <= op_div_d;
    end
  end

  assign busy         = busy_q;
  assign result_ready = ready_q;
  assign result       = result_q;
  assign exception    = exc_q;
  assign tag_out      = tag_out_q;
  assign op_div       = op_div_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// ============================================================================
// Module      : tb_multdiv_iter
// Description : Self-checking bench for multdiv_iter at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult, start_div, flush;
  logic [31:0] operand_a, operand_b, result;
  logic [4:0]  tag_in, tag_out;
  logic        busy, result_ready, exception, op_div;

  logic        start_mult_8, start_div_8, flush_8;
  logic [7:0]  operand_a_8, operand_b_8, result_8;
  logic [2:0]  tag_in_8, tag_out_8;
  logic        busy_8, result_ready_8, exception_8, op_div_8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  multdiv_iter #(.WIDTH(32), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .operand_a(operand_a), .operand_b(operand_b), .tag_in(tag_in), .flush(flush),
    .busy(busy), .result_ready(result_ready), .result(result), .exception(exception),
    .tag_out(tag_out), .op_div(op_div)
  );

  multdiv_iter #(.WIDTH(8), .TAG_W(3)) dut8 (
    .clock(clock), .reset(reset), .start_mult(start_mult_8), .start_div(start_div_8),
    .operand_a(operand_a_8), .operand_b(operand_b_8), .tag_in(tag_in_8), .flush(flush_8),
    .busy(busy_8), .result_ready(result_ready_8), .result(result_8), .exception(exception_8),
    .tag_out(tag_out_8), .op_div(op_div_8)
  );

  // Reference: true signed arithmetic, then truncation to w bits
  function automatic longint sext(input longint x, input int w);
    longint m;
    m = longint'(1) << w;
    x = x & (m - 1);
    if (x >= (m >>> 1)) x = x - m;
    return x;
  endfunction

  function automatic void model(input int w, input bit is_div, input longint a, input longint b,
                                output longint res, output bit exc);
    longint sa, sb, full;
    sa = sext(a, w);
    sb = sext(b, w);
    if (is_div && sb == 0) begin
      res = 0;
      exc = 1'b1;
      return;
    end
    full = is_div ? (sa / sb) : (sa * sb);
    res  = full & ((longint'(1) << w) - 1);
    exc  = (sext(full, w) != full);
  endfunction

  task automatic issue32(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
    start_mult = m; start_div = d; operand_a = a; operand_b = b; tag_in = t;
    @(posedge clock); #1;
    start_mult = 1'b0; start_div = 1'b0;
  endtask

  task automatic wait_ready32(output int cyc, output int busy_low);
    cyc = 1; busy_low = 0;
    while (result_ready !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clock); #1;
      cyc++;
    end
    if (busy !== 1'b1) busy_low++;
  endtask

  task automatic issue8(input bit m, input bit d, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] t);
    start_mult_8 = m; start_div_8 = d; operand_a_8 = a; operand_b_8 = b; tag_in_8 = t;
    @(posedge clock); #1;
    start_mult_8 = 1'b0; start_div_8 = 1'b0;
  endtask

  task automatic wait_ready8(output int cyc);
    cyc = 1;
    while (result_ready_8 !== 1'b1 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({busy, result_ready, result, exception, tag_out, op_div} !== 40'h0)
      $display("FAIL reset32: got %h expected 0", {busy, result_ready, result, exception, tag_out, op_div});
    else n_pass++;
    n_checks++;
    if ({busy_8, result_ready_8, result_8, exception_8, tag_out_8, op_div_8} !== 15'h0)
      $display("FAIL reset8: got %h expected 0", {busy_8, result_ready_8, result_8, exception_8, tag_out_8, op_div_8});
    else n_pass++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mult_directed;
    logic [31:0] av[3] = '{32'd7, 32'h00010000, 32'h80000000};
    logic [31:0] bv[3] = '{32'hFFFFFFFA, 32'h00010000, 32'd1};
    logic [31:0] rv[3] = '{32'hFFFFFFD6, 32'h00000000, 32'h80000000};
    bit          ev[3] = '{1'b0, 1'b1, 1'b0};
    int cyc, bl;
    for (int i = 0; i < 3; i++) begin
      issue32(1'b1, 1'b0, av[i], bv[i], 5'(5 + i));
      wait_ready32(cyc, bl);
      n_checks++;
      if (cyc != 33 || bl != 0)
        $display("FAIL mult_timing[%0d]: ready cycle %0d busy-low %0d, expected 33 and 0", i, cyc, bl);
      else n_pass++;
      n_checks++;
      if ({result, exception, tag_out, op_div} !== {rv[i], ev[i], 5'(5 + i), 1'b0})
        $display("FAIL mult_dir[%0d]: got %h expected %h", i,
                 {result, exception, tag_out, op_div}, {rv[i], ev[i], 5'(5 + i), 1'b0});
      else n_pass++;
      @(posedge clock); #1;
      n_checks++;
      if ({busy, result_ready, result} !== {1'b0, 1'b0, rv[i]})
        $display("FAIL mult_after[%0d]: got %h expected %h", i, {busy, result_ready, result}, {2'b00, rv[i]});
      else n_pass++;
    end
  endtask

  task automatic test_div_directed;
    logic [31:0] av[3] = '{32'hFFFFFFF9, 32'd5, 32'h80000000};
    logic [31:0] bv[3] = '{32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] rv[3] = '{32'hFFFFFFFD, 32'h00000000, 32'h80000000};
    bit          ev[3] = '{1'b0, 1'b1, 1'b1};
    int cyc, bl;
    for (int i = 0; i < 3; i++) begin
      issue32(1'b0, 1'b1, av[i], bv[i], 5'(20 + i));
      wait_ready32(cyc, bl);
      n_checks++;
      if (cyc != 33 || bl != 0 || {result, exception, tag_out, op_div} !== {rv[i], ev[i], 5'(20 + i), 1'b1})
        $display("FAIL div_dir[%0d]: got cyc %0d %h expected cyc 33 %h", i, cyc,
                 {result, exception, tag_out, op_div}, {rv[i], ev[i], 5'(20 + i), 1'b1});
      else n_pass++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b;
    logic [4:0]  t;
    bit          dv, exc;
    longint      res;
    int          cyc, bl;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; t = 5'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: begin a = $urandom_range(0, 70000); b = $urandom_range(0, 70000); end
        default: ;
      endcase
      dv = 1'($urandom_range(0, 1));
      issue32(!dv, dv, a, b, t);
      wait_ready32(cyc, bl);
      model(32, dv, longint'(a), longint'(b), res, exc);
      n_checks++;
      if (cyc != 33 || bl != 0 || {result, exception, tag_out, op_div} !== {res[31:0], exc, t, dv})
        $display("FAIL rand32[%0d] %s a=%h b=%h: got cyc %0d %h expected %h", i, dv ? "div" : "mul",
                 a, b, cyc, {result, exception, tag_out, op_div}, {res[31:0], exc, t, dv});
      else n_pass++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_ignore_start;
    int cyc, bl;
    issue32(1'b1, 1'b0, 32'd300, 32'd300, 5'd3);
    start_div = 1'b1; operand_a = 32'd77; operand_b = 32'd0; tag_in = 5'd30;
    repeat (32) @(posedge clock);
    #1;
    start_div = 1'b0;
    n_checks++;
    if ({result_ready, result, exception, tag_out, op_div} !== {1'b1, 32'd90000, 1'b0, 5'd3, 1'b0})
      $display("FAIL ignore_start: got %h expected %h", {result_ready, result, exception, tag_out, op_div},
               {1'b1, 32'd90000, 1'b0, 5'd3, 1'b0});
    else n_pass++;
    @(posedge clock); #1;
    wait_ready32(cyc, bl);
    n_checks++;
    if (bl == 0 || cyc != 100)
      $display("FAIL ignore_start_idle: got extra result at cycle %0d busy-low %0d, expected none", cyc, bl);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int     cyc, bl;
    longint res;
    bit     exc;
    issue32(1'b1, 1'b0, 32'd123, 32'hFFFFFFFC, 5'd1);
    wait_ready32(cyc, bl);
    n_checks++;
    if (cyc != 33 || result !== 32'hFFFFFE14 || exception !== 1'b0)
      $display("FAIL b2b_first: got cyc %0d %h/%b expected cyc 33 fffffe14/0", cyc, result, exception);
    else n_pass++;
    issue32(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 5'd9);
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL b2b_busy: got %b expected 1", busy);
    else n_pass++;
    wait_ready32(cyc, bl);
    model(32, 1'b1, longint'(32'hFFFFFF9C), 64'd7, res, exc);
    n_checks++;
    if (cyc != 33 || bl != 0 || {result, exception, tag_out, op_div} !== {res[31:0], exc, 5'd9, 1'b1})
      $display("FAIL b2b_second: got cyc %0d %h expected cyc 33 %h", cyc,
               {result, exception, tag_out, op_div}, {res[31:0], exc, 5'd9, 1'b1});
    else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_both_starts;
    int cyc, bl;
    issue32(1'b1, 1'b1, 32'd100, 32'd7, 5'd11);
    wait_ready32(cyc, bl);
    n_checks++;
    if (cyc != 33 || {result, exception, tag_out, op_div} !== {32'd700, 1'b0, 5'd11, 1'b0})
      $display("FAIL both_starts: got cyc %0d %h expected cyc 33 %h", cyc,
               {result, exception, tag_out, op_div}, {32'd700, 1'b0, 5'd11, 1'b0});
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL both_starts_idle: got busy %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    int          readies;
    prev = result;
    issue32(1'b1, 1'b0, 32'd11, 32'd13, 5'd2);
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL flush_busy: got %b expected 0", busy);
    else n_pass++;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      if (result_ready === 1'b1) readies++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (readies != 0 || result !== prev)
      $display("FAIL flush_result: got %0d readies result %h expected 0 readies result %h", readies, result, prev);
    else n_pass++;

    start_mult = 1'b1; flush = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
    @(posedge clock); #1;
    start_mult = 1'b0; flush = 1'b0;
    readies = 0;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL flush_start_busy: got %b expected 0", busy);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (result_ready === 1'b1) readies++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (readies != 0)
      $display("FAIL flush_start_ready: got %0d readies expected 0", readies);
    else n_pass++;
  endtask

  task automatic test_reset_midop;
    int cyc, bl, readies;
    issue32(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 5'd5);
    wait_ready32(cyc, bl);
    @(posedge clock); #1;
    issue32(1'b0, 1'b1, 32'd1000, 32'd3, 5'd7);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if ({busy, result_ready, result, exception, tag_out, op_div} !== 40'h0)
      $display("FAIL reset_midop: got %h expected 0", {busy, result_ready, result, exception, tag_out, op_div});
    else n_pass++;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      if (result_ready === 1'b1) readies++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (readies != 0)
      $display("FAIL reset_midop_ready: got %0d readies expected 0", readies);
    else n_pass++;
  endtask

  task automatic test_width8;
    logic [7:0] a, b;
    logic [2:0] t;
    bit         dv, exc;
    longint     res;
    int         cyc;
    issue8(1'b1, 1'b0, 8'd100, 8'd2, 3'd6);
    wait_ready8(cyc);
    n_checks++;
    if (cyc != 9 || {result_8, exception_8, tag_out_8, op_div_8} !== {8'hC8, 1'b1, 3'd6, 1'b0})
      $display("FAIL w8_mult: got cyc %0d %h expected cyc 9 %h", cyc,
               {result_8, exception_8, tag_out_8, op_div_8}, {8'hC8, 1'b1, 3'd6, 1'b0});
    else n_pass++;
    @(posedge clock); #1;
    issue8(1'b0, 1'b1, 8'h80, 8'd3, 3'd1);
    wait_ready8(cyc);
    n_checks++;
    if (cyc != 9 || {result_8, exception_8, tag_out_8, op_div_8} !== {8'hD6, 1'b0, 3'd1, 1'b1})
      $display("FAIL w8_div: got cyc %0d %h expected cyc 9 %h", cyc,
               {result_8, exception_8, tag_out_8, op_div_8}, {8'hD6, 1'b0, 3'd1, 1'b1});
    else n_pass++;
    @(posedge clock); #1;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); t = 3'($urandom);
      if ($urandom_range(0, 5) == 0) b = 8'd0;
      if ($urandom_range(0, 5) == 0) begin a = 8'h80; b = 8'hFF; end
      dv = 1'($urandom_range(0, 1));
      issue8(!dv, dv, a, b, t);
      wait_ready8(cyc);
      model(8, dv, longint'(a), longint'(b), res, exc);
      n_checks++;
      if (cyc != 9 || {result_8, exception_8, tag_out_8, op_div_8} !== {res[7:0], exc, t, dv})
        $display("FAIL rand8[%0d] %s a=%h b=%h: got cyc %0d %h expected %h", i, dv ? "div" : "mul",
                 a, b, cyc, {result_8, exception_8, tag_out_8, op_div_8}, {res[7:0], exc, t, dv});
      else n_pass++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    operand_a = '0; operand_b = '0; tag_in = '0;
    flush_8 = 1'b0; start_mult_8 = 1'b0; start_div_8 = 1'b0;
    operand_a_8 = '0; operand_b_8 = '0; tag_in_8 = '0;
    #1;
    test_reset;
    test_mult_directed;
    test_div_directed;
    test_random32;
    test_ignore_start;
    test_back_to_back;
    test_both_starts;
    test_flush;
    test_reset_midop;
    test_width8;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
